// File: rtl/pss_intr_pkg.sv
// Shared constants and types for the peripheral sub-system interrupt controller.
// Register offsets are byte addresses on the 5-bit APB address bus.
package pss_intr_pkg;

    localparam int MAX_SRC = 7;

    typedef logic [MAX_SRC-1:0] src_vec_t;

    localparam logic [4:0] ADDR_STATUS = 5'h00;
    localparam logic [4:0] ADDR_MASK   = 5'h04;
    localparam logic [4:0] ADDR_CLEAR  = 5'h08;
    localparam logic [4:0] ADDR_MODE   = 5'h0C;
    localparam logic [4:0] ADDR_VECTOR = 5'h10;

    localparam logic [2:0] NO_IRQ = 3'd7;

endpackage

// File: rtl/pss_intr_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of the active vector,
// or NO_IRQ when nothing is active.
module pss_intr_prio_enc
    import pss_intr_pkg::*;
(
    input  src_vec_t    active,
    output logic [2:0]  vector
);

    // Scan from the top down so the lowest index overwrites last and wins.
    always_comb begin
        vector = NO_IRQ;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (active[i]) vector = 3'(i);
        end
    end

endmodule

// File: rtl/pss_intr_ctrl.sv
// Interrupt controller with edge/level sources, mask, W1C clear and APB access.
// Optional build macro PSS_INTR_SYNC_EN inserts a 2-flop input synchronizer.
module pss_intr_ctrl
    import pss_intr_pkg::*;
#(
    parameter int NUM_SRC = 5
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NUM_SRC-1:0] IREQ,
    output logic               IRQ,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [4:0]         PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY
);

    logic [NUM_SRC-1:0] ireq_s;
    logic [NUM_SRC-1:0] ireq_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] wdata;
    logic [4:0]         word_addr;
    logic [2:0]         vector;
    logic               wr_en;
    logic               armed;
    logic [1:0]         arm_cnt;
    logic               unused_bits;

`ifdef PSS_INTR_SYNC_EN
    localparam int ARM_CYC = 3;
    logic [NUM_SRC-1:0] sync_p0;
    logic [NUM_SRC-1:0] sync_p1;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= IREQ;
            sync_p1 <= sync_p0;
        end
    end

    assign ireq_s = sync_p1;
`else
    localparam int ARM_CYC = 1;
    assign ireq_s = IREQ;
`endif

    assign word_addr   = {PADDR[4:2], 2'b00};
    assign wdata       = PWDATA[NUM_SRC-1:0];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign unused_bits = ^{PWDATA, PADDR[1:0]};
    assign PREADY      = 1'b1;

    // Edge detection stays off until ireq_d holds a real sample of the input,
    // so a line already high when reset releases is not mistaken for a rise.
    assign armed = (arm_cnt == 2'(ARM_CYC));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end

    assign clr_bits    = (wr_en && word_addr == ADDR_CLEAR) ? wdata : '0;
    assign edge_set    = armed ? (ireq_s & ~ireq_d) : '0;
    // Set beats clear for edge sources; level sources simply follow the input.
    assign pending_nxt = (mode & ireq_s) | (~mode & ((pending & ~clr_bits) | edge_set));
    assign active      = pending & mask;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ireq_d  <= '0;
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
            IRQ     <= 1'b0;
        end else begin
            ireq_d  <= ireq_s;
            pending <= pending_nxt;
            IRQ     <= |active;
            if (wr_en && word_addr == ADDR_MASK) mask <= wdata;
            if (wr_en && word_addr == ADDR_MODE) mode <= wdata;
        end
    end

    pss_intr_prio_enc u_prio_enc (
        .active (src_vec_t'(active)),
        .vector (vector)
    );

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (word_addr)
                ADDR_STATUS: PRDATA = 32'(pending);
                ADDR_MASK:   PRDATA = 32'(mask);
                ADDR_MODE:   PRDATA = 32'(mode);
                ADDR_VECTOR: PRDATA = 32'(vector);
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pss_intr_ctrl.sv
// Directed bench for pss_intr_ctrl (default build, no input synchronizer).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pss_intr_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [4:0]  IREQ = '0;
    logic        IRQ;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd;

    always #10 PCLK = ~PCLK;

    pss_intr_ctrl #(.NUM_SRC(5)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .IREQ    (IREQ),
        .IRQ     (IRQ),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [4:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a;
        #1 d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    initial begin
        // Reset state
        wait_neg(3);
        #1 chk("irq_in_reset", 32'(IRQ), 32'h0);
        wait_neg(1);
        PRESET = 1'b0;
        wait_neg(3);
        chk("idle_prdata", PRDATA, 32'h0);
        chk("pready", 32'(PREADY), 32'h1);
        apb_rd(5'h00, rd); chk("rst_status", rd, 32'h0);
        apb_rd(5'h04, rd); chk("rst_mask", rd, 32'h0);
        apb_rd(5'h0C, rd); chk("rst_mode", rd, 32'h0);
        apb_rd(5'h10, rd); chk("rst_vector", rd, 32'h7);
        apb_rd(5'h08, rd); chk("rst_clear_rd", rd, 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);

        // Mask register, byte-address bits ignored, unmapped addresses
        apb_wr(5'h04, 32'hFFFF_FFFF);
        apb_rd(5'h04, rd); chk("mask_unused_bits", rd, 32'h1F);
        apb_rd(5'h07, rd); chk("mask_byte_addr", rd, 32'h1F);
        apb_wr(5'h14, 32'h0000_0000);
        apb_rd(5'h14, rd); chk("unmapped_rd", rd, 32'h0);
        apb_rd(5'h04, rd); chk("unmapped_no_wr", rd, 32'h1F);

        // Single edge pulse on source 2, then clear
        @(negedge PCLK) IREQ = 5'b00100;
        @(negedge PCLK) IREQ = 5'b00000;
        #1 chk("irq_lat_e0", 32'(IRQ), 32'h0);
        wait_neg(1);
        #1 chk("irq_lat_e1", 32'(IRQ), 32'h1);
        apb_rd(5'h00, rd); chk("src2_status", rd, 32'h04);
        apb_rd(5'h10, rd); chk("src2_vector", rd, 32'h2);
        apb_wr(5'h08, 32'h04);
        apb_rd(5'h00, rd); chk("src2_cleared", rd, 32'h0);
        chk("src2_irq_hold", 32'(IRQ), 32'h1);
        wait_neg(1);
        #1 chk("src2_irq_fall", 32'(IRQ), 32'h0);

        // Priority between sources 4 and 1
        @(negedge PCLK) IREQ = 5'b10010;
        wait_neg(2);
        IREQ = 5'b00000;
        apb_rd(5'h00, rd); chk("prio_status", rd, 32'h12);
        apb_rd(5'h10, rd); chk("prio_vec1", rd, 32'h1);
        apb_wr(5'h08, 32'h02);
        apb_rd(5'h10, rd); chk("prio_vec4", rd, 32'h4);
        wait_neg(1);
        #1 chk("prio_irq_still", 32'(IRQ), 32'h1);
        apb_wr(5'h08, 32'h10);
        apb_rd(5'h10, rd); chk("prio_vec_none", rd, 32'h7);
        wait_neg(1);
        #1 chk("prio_irq_low", 32'(IRQ), 32'h0);

        // Level source 0
        apb_wr(5'h0C, 32'h01);
        apb_wr(5'h04, 32'h01);
        @(negedge PCLK) IREQ = 5'b00001;
        wait_neg(2);
        #1 chk("lvl_irq_high", 32'(IRQ), 32'h1);
        apb_wr(5'h08, 32'h01);
        apb_rd(5'h00, rd); chk("lvl_clear_ignored", rd, 32'h01);
        @(negedge PCLK) IREQ = 5'b00000;
        wait_neg(1);
        apb_rd(5'h00, rd); chk("lvl_status_drop", rd, 32'h0);
        wait_neg(1);
        #1 chk("lvl_irq_fall", 32'(IRQ), 32'h0);
        apb_wr(5'h0C, 32'h00);

        // Edge source 3: set wins over a same-cycle clear
        apb_wr(5'h04, 32'h08);
        @(negedge PCLK) IREQ = 5'b01000;
        @(negedge PCLK) IREQ = 5'b00000;
        wait_neg(1);
        apb_rd(5'h00, rd); chk("src3_status", rd, 32'h08);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 5'h08; PWDATA = 32'h08; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1; IREQ = 5'b01000;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; IREQ = 5'b00000;
        apb_rd(5'h00, rd); chk("set_beats_clear", rd, 32'h08);
        apb_wr(5'h08, 32'h08);
        apb_rd(5'h00, rd); chk("src3_cleared", rd, 32'h0);

        // Masked pending, late unmask, then asynchronous reset
        apb_wr(5'h04, 32'h00);
        apb_wr(5'h0C, 32'h04);
        @(negedge PCLK) IREQ = 5'b00001;
        @(negedge PCLK) IREQ = 5'b00000;
        wait_neg(2);
        apb_rd(5'h00, rd); chk("masked_status", rd, 32'h01);
        chk("masked_irq", 32'(IRQ), 32'h0);
        apb_wr(5'h04, 32'h01);
        #1 chk("unmask_irq_w", 32'(IRQ), 32'h0);
        wait_neg(1);
        #1 chk("unmask_irq_w1", 32'(IRQ), 32'h1);
        #3 PRESET = 1'b1;
        #1 chk("async_irq_drop", 32'(IRQ), 32'h0);
        apb_rd(5'h00, rd); chk("arst_status", rd, 32'h0);
        apb_rd(5'h04, rd); chk("arst_mask", rd, 32'h0);
        apb_rd(5'h0C, rd); chk("arst_mode", rd, 32'h0);
        apb_rd(5'h10, rd); chk("arst_vector", rd, 32'h7);

        // Source 1 already high at reset release must not latch
        IREQ = 5'b00010;
        wait_neg(2);
        PRESET = 1'b0;
        apb_wr(5'h04, 32'h02);
        wait_neg(2);
        apb_rd(5'h00, rd); chk("high_at_release", rd, 32'h0);
        #1 chk("high_at_release_irq", 32'(IRQ), 32'h0);
        @(negedge PCLK) IREQ = 5'b00000;
        @(negedge PCLK) IREQ = 5'b00010;
        wait_neg(2);
        apb_rd(5'h00, rd); chk("rise_after_release", rd, 32'h02);
        #1 chk("rise_after_release_irq", 32'(IRQ), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
